// File: rtl/frame_timing_gen.sv
// Raster timing generator: derives a Clk/2 pixel clock and steps the DrawX/DrawY
// counters on each advance cycle, decoding sync/blank and line/frame pulses.
module frame_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_clk,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       pixel_clk_q, pixel_clk_d;
    logic [9:0] draw_x_q, draw_x_d;
    logic [9:0] draw_y_q, draw_y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    // Next-state: counters step and outputs re-decode only when pixel_clk is high
    always_comb begin
        pixel_clk_d   = ~pixel_clk_q;
        draw_x_d      = draw_x_q;
        draw_y_d      = draw_y_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_d       = blank_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pixel_clk_q) begin
            // >= rather than == so an out-of-range count still recovers on the next advance
            if (draw_x_q >= H_LAST) begin
                draw_x_d = 10'd0;
                if (draw_y_q >= V_LAST) begin
                    draw_y_d = 10'd0;
                end else begin
                    draw_y_d = draw_y_q + 10'd1;
                end
            end else begin
                draw_x_d = draw_x_q + 10'd1;
                draw_y_d = draw_y_q;
            end
            hs_d          = ~((draw_x_d >= HS_START) && (draw_x_d < HS_END));
            vs_d          = ~((draw_y_d >= VS_START) && (draw_y_d < VS_END));
            blank_d       = (draw_x_d < H_VIS) && (draw_y_d < V_VIS);
            line_start_d  = (draw_x_d == 10'd0);
            frame_start_d = (draw_x_d == 10'd0) && (draw_y_d == 10'd0);
        end else begin
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // State register with synchronous reset to the last raster position
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_clk_q   <= 1'b0;
            draw_x_q      <= H_LAST;
            draw_y_q      <= V_LAST;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_clk_q   <= pixel_clk_d;
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_clk   = pixel_clk_q;
    assign DrawX       = draw_x_q;
    assign DrawY       = draw_y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/frame_timing_gen.md
FRAME_TIMING_GEN -- requirements
Module: frame_timing_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL provide parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, meaning horizontal front porch, sync width and back porch in pixels.
REQ-003 SHALL provide parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, meaning the vertical equivalents in lines.
REQ-004 SHALL have port Clk, input, 1, the 50 MHz system clock; every flop is on its rising edge.
REQ-005 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port pixel_clk, output, 1, the 25 MHz pixel clock (Clk/2) that feeds downstream sprite ROM/palette stages.
REQ-007 SHALL have port hs, output, 1, horizontal sync, active low.
REQ-008 SHALL have port vs, output, 1, vertical sync, active low.
REQ-009 SHALL have port blank, output, 1, display-enable; 1 = visible pixel (downstream draws only when high), 0 = blanking.
REQ-010 SHALL have ports DrawX and DrawY, output, 10 each, the current horizontal and vertical counts.
REQ-011 SHALL have port line_start, output, 1, one-Clk pulse when DrawX wraps to 0.
REQ-012 SHALL have port frame_start, output, 1, one-Clk pulse when DrawX and DrawY both wrap to 0.

Function
REQ-013 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL likewise (525).
REQ-014 SHALL toggle pixel_clk on every Clk edge when not in reset.
REQ-015 SHALL define an advance cycle as any Clk edge where pixel_clk is currently 1; counters and all decoded outputs update only on advance cycles.
REQ-016 On advance: DrawX increments; at H_TOTAL-1 it wraps to 0 and DrawY increments; DrawY at V_TOTAL-1 with DrawX wrap wraps to 0.
REQ-017 SHALL never let DrawX exceed H_TOTAL-1 or DrawY exceed V_TOTAL-1.
REQ-018 hs, vs and blank SHALL be registered and decoded from the next counter values, so they change on the same edge as DrawX/DrawY with zero skew.
REQ-019 hs SHALL be 0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-020 vs SHALL be 0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-021 blank SHALL be 1 iff DrawX < H_ACTIVE and DrawY < V_ACTIVE.
REQ-022 line_start SHALL be 1 for exactly the one Clk cycle following the advance that set DrawX to 0; else 0.
REQ-023 frame_start SHALL be 1 for exactly the one Clk cycle following the advance that set (DrawX,DrawY) to (0,0); it coincides with a line_start pulse.
REQ-024 Counter comparisons SHALL use at least 10-bit unsigned arithmetic; no truncation for the default parameters.

Reset
REQ-025 While Reset=1: pixel_clk=0, DrawX=H_TOTAL-1, DrawY=V_TOTAL-1, hs=1, vs=1, blank=0, line_start=0, frame_start=0.
REQ-026 Reset asserted mid-frame SHALL take effect on the next Clk edge regardless of pixel_clk phase.
REQ-027 After Reset deasserts, the first advance (second Clk edge) SHALL wrap to (0,0), set blank=1, and pulse line_start and frame_start.

Verification
REQ-028 Reset 3 cycles, release -> edge 1 pixel_clk=1; edge 2 DrawX=0, DrawY=0, blank=1; next cycle frame_start=1, line_start=1 for one Clk.
REQ-029 Free-run one line -> DrawX period 1600 Clk; hs low for exactly 192 Clk starting when DrawX=656; blank falls when DrawX=640.
REQ-030 Free-run one frame -> frame_start period 840000 Clk; vs low for exactly 3200 Clk (DrawY 490..491); 525 line_start pulses per frame.
REQ-031 Corner wrap at (799,524) -> next advance gives (0,0), hs=1, vs=1, blank=1, both pulses asserted.
REQ-032 Assert Reset for one Clk at DrawX=300, DrawY=200 with pixel_clk=1 -> all outputs at reset values on that edge; restart per REQ-027.
REQ-033 Bench SHALL assert every Clk: DrawX<800, DrawY<525, blank implies hs=1 and vs=1.
